// File: rtl/shift_serializer_pkg.sv
// Shared types and constants for the shift_serializer block and its counter.
package shift_serializer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_t;

    localparam logic LSB_FIRST = 1'b0;
    localparam logic MSB_FIRST = 1'b1;

endpackage

// File: rtl/bit_down_counter.sv
// Remaining-bit counter: loads the frame length, counts down per strobe, flags the final bit.
module bit_down_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (dec && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
        end
    end

    assign count = cnt_reg;
    assign last  = (cnt_reg == CNT_W'(1));

endmodule

// File: rtl/shift_serializer.sv
// Parallel-in/serial-out shifter with valid/ready load and frame-complete pulse.
// Define SHIFT_SERIALIZER_PARITY_EN to append an even-parity bit to each frame.
module shift_serializer
    import shift_serializer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 2)
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic             msb_first,
    input  logic             en,
    output logic             s_out,
    output logic             s_valid,
    output logic             busy,
    output logic             done
);

`ifdef SHIFT_SERIALIZER_PARITY_EN
    localparam int FRAME_BITS = WIDTH + 1;
`else
    localparam int FRAME_BITS = WIDTH;
`endif

    state_t           state_reg;
    logic [WIDTH-1:0] sh_reg;
    logic             dir_reg;
    logic             done_reg;

    logic [CNT_W-1:0] cnt;
    logic             last;
    logic             frame_busy;
    logic             advance;
    logic             accept;
    logic             data_bit;
    logic [WIDTH-1:0] sh_left;
    logic [WIDTH-1:0] sh_right;

    // Zero-filled shifts toward either output end.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (gi == 0) begin : g_lo
                assign sh_left[gi]  = 1'b0;
                assign sh_right[gi] = sh_reg[gi+1];
            end else if (gi == WIDTH - 1) begin : g_hi
                assign sh_left[gi]  = sh_reg[gi-1];
                assign sh_right[gi] = 1'b0;
            end else begin : g_mid
                assign sh_left[gi]  = sh_reg[gi-1];
                assign sh_right[gi] = sh_reg[gi+1];
            end
        end
    endgenerate

    assign frame_busy = (state_reg != IDLE);
    assign advance    = frame_busy && en;
    assign load_ready = !frame_busy || (last && en);
    assign accept     = load_valid && load_ready;
    assign data_bit   = (dir_reg == MSB_FIRST) ? sh_reg[WIDTH-1] : sh_reg[0];

    bit_down_counter #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk     (clk),
        .rst_b   (rst_b),
        .load    (accept),
        .load_val(CNT_W'(FRAME_BITS)),
        .dec     (advance),
        .count   (cnt),
        .last    (last)
    );

`ifdef SHIFT_SERIALIZER_PARITY_EN
    logic parity_reg;
    logic to_par;

    // Counter still holds 2 while the final data bit is on the line.
    assign to_par = (state_reg == SHIFT) && (cnt == CNT_W'(2));
    assign s_out  = frame_busy && ((state_reg == PAR) ? parity_reg : data_bit);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            parity_reg <= 1'b0;
        end else if (accept) begin
            parity_reg <= ^data_in;
        end
    end
`else
    logic unused_cnt;
    assign unused_cnt = ^cnt;
    assign s_out      = frame_busy && data_bit;
`endif

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_reg <= IDLE;
            sh_reg    <= '0;
            dir_reg   <= LSB_FIRST;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= advance && last;
            if (accept) begin
                state_reg <= SHIFT;
                sh_reg    <= data_in;
                dir_reg   <= msb_first;
            end else if (advance) begin
                if (state_reg == SHIFT) begin
                    sh_reg <= (dir_reg == MSB_FIRST) ? sh_left : sh_right;
                end
                if (last) begin
                    state_reg <= IDLE;
                end
`ifdef SHIFT_SERIALIZER_PARITY_EN
                else if (to_par) begin
                    state_reg <= PAR;
                end
`endif
            end
        end
    end

    assign s_valid = frame_busy;
    assign busy    = frame_busy;
    assign done    = done_reg;

endmodule

// File: tb/tb_shift_serializer.sv
// Self-checking bench for shift_serializer (WIDTH = 8) using a queue-of-bits frame model.
module tb_shift_serializer;

`ifdef SHIFT_SERIALIZER_PARITY_EN
    localparam int FL = 9;
    localparam logic [FL-1:0]   EXP_MSB = {8'hC4, 1'b1};
    localparam logic [FL-1:0]   EXP_LSB = {8'h23, 1'b1};
    localparam logic [2*FL-1:0] EXP_B2B = {8'hFF, 1'b0, 8'h00, 1'b0};
`else
    localparam int FL = 8;
    localparam logic [FL-1:0]   EXP_MSB = 8'hC4;
    localparam logic [FL-1:0]   EXP_LSB = 8'h23;
    localparam logic [2*FL-1:0] EXP_B2B = {8'hFF, 8'h00};
`endif

    logic       clk;
    logic       rst_b;
    logic       load_valid;
    logic       load_ready;
    logic [7:0] data_in;
    logic       msb_first;
    logic       en;
    logic       s_out;
    logic       s_valid;
    logic       busy;
    logic       done;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: bits still to be sent, in line order.
    bit q[$];
    bit done_exp = 1'b0;
    int acc_cnt  = 0;

    logic [4:0] obs_v;

    shift_serializer #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .data_in   (data_in),
        .msb_first (msb_first),
        .en        (en),
        .s_out     (s_out),
        .s_valid   (s_valid),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {s_out, s_valid, busy, done, load_ready}
    function automatic logic [4:0] exp_vec();
        logic o;
        logic v;
        logic r;
        o = (q.size() > 0) ? q[0] : 1'b0;
        v = (q.size() > 0);
        r = (q.size() == 0) || ((q.size() == 1) && en);
        return {o, v, v, done_exp, r};
    endfunction

    task automatic drive(input logic v, input logic [7:0] d, input logic m, input logic e);
        @(negedge clk);
        load_valid = v;
        data_in    = d;
        msb_first  = m;
        en         = e;
        #1;
    endtask

    task automatic step();
        bit acc;
        bit fin;
        acc = load_valid && ((q.size() == 0) || ((q.size() == 1) && en));
        fin = (q.size() == 1) && en;
        @(posedge clk);
        if (en && (q.size() > 0)) void'(q.pop_front());
        if (acc) begin
            for (int i = 0; i < 8; i++) q.push_back(msb_first ? data_in[7-i] : data_in[i]);
`ifdef SHIFT_SERIALIZER_PARITY_EN
            q.push_back(^data_in);
`endif
            acc_cnt++;
        end
        done_exp = fin;
    endtask

    task automatic test_reset();
        #3;
        obs_v = {s_out, s_valid, busy, done, load_ready};
        vectors++;
        if (obs_v !== 5'b00001) begin
            miscompares++;
            $display("FAIL reset_state: got %b want %b", obs_v, 5'b00001);
        end
        @(negedge clk);
        rst_b = 1'b1;
        for (int k = 0; k < 2; k++) begin
            drive(0, 8'h00, 0, 1);
            obs_v = {s_out, s_valid, busy, done, load_ready};
            vectors++;
            if (obs_v !== exp_vec()) begin
                miscompares++;
                $display("FAIL reset_release cyc%0d: got %b want %b", k, obs_v, exp_vec());
            end
            step();
        end
    endtask

    task automatic test_order(input logic m, input logic [FL-1:0] want, input string tag);
        logic [FL-1:0] bits = '0;
        int dones = 0;
        for (int k = 0; k < 12; k++) begin
            drive(k == 0, 8'hC4, m, 1);
            obs_v = {s_out, s_valid, busy, done, load_ready};
            vectors++;
            if (obs_v !== exp_vec()) begin
                miscompares++;
                $display("FAIL %s cyc%0d: got %b want %b", tag, k, obs_v, exp_vec());
            end
            if (s_valid) bits = {bits[FL-2:0], s_out};
            if (done) dones++;
            step();
        end
        vectors++;
        if (bits !== want) begin
            miscompares++;
            $display("FAIL %s_bits: got %b want %b", tag, bits, want);
        end
        vectors++;
        if (dones != 1) begin
            miscompares++;
            $display("FAIL %s_done_count: got %0d want 1", tag, dones);
        end
    endtask

    task automatic test_en_toggle();
        int valid_cycles = 0;
        for (int k = 0; k < 24; k++) begin
            drive((k == 0) || (k == 6), (k == 0) ? 8'hC4 : 8'h5A, 1, (k == 0) || (k % 2 == 0));
            obs_v = {s_out, s_valid, busy, done, load_ready};
            vectors++;
            if (obs_v !== exp_vec()) begin
                miscompares++;
                $display("FAIL en_toggle cyc%0d: got %b want %b", k, obs_v, exp_vec());
            end
            if (s_valid) valid_cycles++;
            step();
        end
        vectors++;
        if (valid_cycles != 2 * FL) begin
            miscompares++;
            $display("FAIL en_toggle_len: got %0d want %0d", valid_cycles, 2 * FL);
        end
    endtask

    task automatic test_back_to_back();
        logic [2*FL-1:0] bits = '0;
        int first = -1;
        int lastv = -1;
        int nvalid = 0;
        int dones = 0;
        int base;
        base = acc_cnt;
        for (int k = 0; k < 24; k++) begin
            drive((acc_cnt - base) < 2, ((acc_cnt - base) == 0) ? 8'hFF : 8'h00, 1, 1);
            obs_v = {s_out, s_valid, busy, done, load_ready};
            vectors++;
            if (obs_v !== exp_vec()) begin
                miscompares++;
                $display("FAIL back_to_back cyc%0d: got %b want %b", k, obs_v, exp_vec());
            end
            if (s_valid) begin
                bits = {bits[2*FL-2:0], s_out};
                if (first < 0) first = k;
                lastv = k;
                nvalid++;
            end
            if (done) dones++;
            step();
        end
        vectors++;
        if ((nvalid != 2 * FL) || (lastv - first + 1 != nvalid)) begin
            miscompares++;
            $display("FAIL b2b_contiguous: got %0d bits span %0d want %0d", nvalid, lastv - first + 1, 2 * FL);
        end
        vectors++;
        if (bits !== EXP_B2B) begin
            miscompares++;
            $display("FAIL b2b_bits: got %b want %b", bits, EXP_B2B);
        end
        vectors++;
        if (dones != 2) begin
            miscompares++;
            $display("FAIL b2b_done_count: got %0d want 2", dones);
        end
    endtask

    task automatic test_reset_midframe();
        int dones = 0;
        drive(1, 8'hC4, 1, 1);
        step();
        repeat (3) begin
            drive(0, 8'h00, 1, 1);
            step();
        end
        #2;
        rst_b      = 1'b0;
        load_valid = 1'b1;
        data_in    = 8'h5A;
        #1;
        q.delete();
        done_exp = 1'b0;
        obs_v = {s_out, s_valid, busy, done, load_ready};
        vectors++;
        if (obs_v !== 5'b00001) begin
            miscompares++;
            $display("FAIL midframe_async_reset: got %b want %b", obs_v, 5'b00001);
        end
        repeat (2) @(posedge clk);
        #1;
        obs_v = {s_out, s_valid, busy, done, load_ready};
        vectors++;
        if (obs_v !== 5'b00001) begin
            miscompares++;
            $display("FAIL midframe_held_reset: got %b want %b", obs_v, 5'b00001);
        end
        @(negedge clk);
        rst_b      = 1'b1;
        load_valid = 1'b0;
        for (int k = 0; k < 12; k++) begin
            drive(0, 8'h00, 0, 1);
            obs_v = {s_out, s_valid, busy, done, load_ready};
            vectors++;
            if (obs_v !== exp_vec()) begin
                miscompares++;
                $display("FAIL midframe_after cyc%0d: got %b want %b", k, obs_v, exp_vec());
            end
            if (done) dones++;
            step();
        end
        vectors++;
        if (dones != 0) begin
            miscompares++;
            $display("FAIL midframe_no_done: got %0d want 0", dones);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            drive(($urandom % 3) != 0, 8'($urandom), 1'($urandom), ($urandom % 4) != 0);
            obs_v = {s_out, s_valid, busy, done, load_ready};
            vectors++;
            if (obs_v !== exp_vec()) begin
                miscompares++;
                $display("FAIL random cyc%0d: got %b want %b", k, obs_v, exp_vec());
            end
            step();
        end
    endtask

    initial begin
        rst_b      = 1'b0;
        load_valid = 1'b0;
        data_in    = 8'h00;
        msb_first  = 1'b0;
        en         = 1'b0;
        test_reset();
        test_order(1'b1, EXP_MSB, "msb_c4");
        test_order(1'b0, EXP_LSB, "lsb_c4");
        test_en_toggle();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
